// File: rtl/pri_dec_2_4_seq.sv
// Sequential 2-to-4 decoder fed by a priority-encoder style {idle, y1, y0} handshake.
// Each accepted code drives a one-hot line for HOLD_CYC cycles, then an all-zero gap of GAP_CYC cycles.
module pri_dec_2_4_seq #(
  parameter int HOLD_CYC = 3,
  parameter int GAP_CYC  = 1,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             y0,
  input  logic             y1,
  input  logic             idle,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [3:0]       d,
  output logic             busy,
  output logic [CNT_W-1:0] idle_cnt,
  output logic [CNT_W-1:0] dec_cnt
);

  localparam int MAX_CYC = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [3:0]         d_q, d_d;
  logic [CNT_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic [CNT_W-1:0]   dec_cnt_q, dec_cnt_d;
  logic               accept;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    logic [3:0] r;
    r = 4'b0000;
    r[idx] = 1'b1;
    return r;
  endfunction

  assign in_ready = (state_q == S_IDLE);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    d_d        = d_q;
    idle_cnt_d = idle_cnt_q;
    dec_cnt_d  = dec_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        d_d = 4'b0000;
        // y1/y0 are only looked at for non-idle codes, so X on them under idle=1 cannot reach d
        if (accept) begin
          if (idle) begin
            idle_cnt_d = sat_inc(idle_cnt_q);
          end else begin
            d_d       = onehot({y1, y0});
            dec_cnt_d = sat_inc(dec_cnt_q);
            cnt_d     = HOLD_LD;
            state_d   = S_DRIVE;
          end
        end
      end
      S_DRIVE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          d_d = 4'b0000;
          if (GAP_CYC > 0) begin
            cnt_d   = GAP_LD;
            state_d = S_GAP;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_GAP: begin
        d_d = 4'b0000;
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        else             state_d = S_IDLE;
      end
      default: begin
        d_d     = 4'b0000;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      d_q        <= 4'b0000;
      idle_cnt_q <= '0;
      dec_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      d_q        <= d_d;
      idle_cnt_q <= idle_cnt_d;
      dec_cnt_q  <= dec_cnt_d;
    end
  end

  assign d        = d_q;
  assign busy     = (state_q != S_IDLE);
  assign idle_cnt = idle_cnt_q;
  assign dec_cnt  = dec_cnt_q;

endmodule

// File: tb/tb_pri_dec_2_4_seq.sv
// Directed bench for pri_dec_2_4_seq: default instance plus a 2-bit-counter instance
// and a HOLD_CYC=1/GAP_CYC=0 instance, all checked against hand-computed values.
module tb_pri_dec_2_4_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // instance A: HOLD_CYC=3, GAP_CYC=1, CNT_W=8
  logic       y0_a = 1'b0, y1_a = 1'b0, idle_a = 1'b0, in_valid_a = 1'b0;
  logic       in_ready_a, busy_a;
  logic [3:0] d_a;
  logic [7:0] idle_cnt_a, dec_cnt_a;

  // instance B: CNT_W=2
  logic       y0_b = 1'b0, y1_b = 1'b0, idle_b = 1'b0, in_valid_b = 1'b0;
  logic       in_ready_b, busy_b;
  logic [3:0] d_b;
  logic [1:0] idle_cnt_b, dec_cnt_b;

  // instance C: HOLD_CYC=1, GAP_CYC=0
  logic       y0_c = 1'b0, y1_c = 1'b0, idle_c = 1'b0, in_valid_c = 1'b0;
  logic       in_ready_c, busy_c;
  logic [3:0] d_c;
  logic [7:0] idle_cnt_c, dec_cnt_c;

  pri_dec_2_4_seq #(.HOLD_CYC(3), .GAP_CYC(1), .CNT_W(8)) u_dut_a (
    .clk(clk), .rst(rst), .y0(y0_a), .y1(y1_a), .idle(idle_a), .in_valid(in_valid_a),
    .in_ready(in_ready_a), .d(d_a), .busy(busy_a), .idle_cnt(idle_cnt_a), .dec_cnt(dec_cnt_a)
  );

  pri_dec_2_4_seq #(.HOLD_CYC(3), .GAP_CYC(1), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst(rst), .y0(y0_b), .y1(y1_b), .idle(idle_b), .in_valid(in_valid_b),
    .in_ready(in_ready_b), .d(d_b), .busy(busy_b), .idle_cnt(idle_cnt_b), .dec_cnt(dec_cnt_b)
  );

  pri_dec_2_4_seq #(.HOLD_CYC(1), .GAP_CYC(0), .CNT_W(8)) u_dut_c (
    .clk(clk), .rst(rst), .y0(y0_c), .y1(y1_c), .idle(idle_c), .in_valid(in_valid_c),
    .in_ready(in_ready_c), .d(d_c), .busy(busy_c), .idle_cnt(idle_cnt_c), .dec_cnt(dec_cnt_c)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // advance one edge, then settle so outputs are sampled away from the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic send_a(input logic i, input logic [1:0] y);
    for (int k = 0; k < 20 && !in_ready_a; k++) step();
    check("ready_timeout", 32'(in_ready_a), 32'd1);
    in_valid_a = 1'b1;
    idle_a     = i;
    {y1_a, y0_a} = y;
    step();
    in_valid_a = 1'b0;
  endtask

  initial begin
    // reset state
    do_reset();
    check("rst_d",        32'(d_a),        32'h0);
    check("rst_busy",     32'(busy_a),     32'd0);
    check("rst_ready",    32'(in_ready_a), 32'd1);
    check("rst_idle_cnt", 32'(idle_cnt_a), 32'd0);
    check("rst_dec_cnt",  32'(dec_cnt_a),  32'd0);

    // test 1: single code 10
    send_a(1'b0, 2'b10);
    for (int j = 0; j < 3; j++) begin
      check("t1_d_hold",    32'(d_a),        32'h4);
      check("t1_busy_hold", 32'(busy_a),     32'd1);
      check("t1_ready_lo",  32'(in_ready_a), 32'd0);
      step();
    end
    check("t1_d_gap",    32'(d_a),        32'h0);
    check("t1_busy_gap", 32'(busy_a),     32'd1);
    check("t1_ready_gap",32'(in_ready_a), 32'd0);
    step();
    check("t1_ready_back", 32'(in_ready_a), 32'd1);
    check("t1_busy_back",  32'(busy_a),     32'd0);
    check("t1_dec_cnt",    32'(dec_cnt_a),  32'd1);

    // test 2: all four codes in order
    do_reset();
    for (int c = 0; c < 4; c++) begin
      send_a(1'b0, 2'(c));
      for (int j = 0; j < 3; j++) begin
        check("t2_d", 32'(d_a), 32'(1 << c));
        step();
      end
      check("t2_d_gap", 32'(d_a), 32'h0);
    end
    check("t2_dec_cnt",  32'(dec_cnt_a),  32'd4);
    check("t2_idle_cnt", 32'(idle_cnt_a), 32'd0);

    // test 3: in_valid held high, idle codes (with y=11 ignored) and code 11
    do_reset();
    in_valid_a = 1'b1;
    idle_a = 1'b1;
    {y1_a, y0_a} = 2'b11;
    step();
    check("t3_idle_cnt1", 32'(idle_cnt_a), 32'd1);
    check("t3_d_idle1",   32'(d_a),        32'h0);
    check("t3_ready1",    32'(in_ready_a), 32'd1);
    step();
    check("t3_idle_cnt2", 32'(idle_cnt_a), 32'd2);
    check("t3_d_idle2",   32'(d_a),        32'h0);
    idle_a = 1'b0;
    step();
    check("t3_d_code11", 32'(d_a),       32'h8);
    check("t3_dec_cnt1", 32'(dec_cnt_a), 32'd1);
    for (int j = 0; j < 3; j++) begin
      step();
      check("t3_dec_busy", 32'(dec_cnt_a), 32'd1);
      check("t3_busy",     32'(busy_a),    32'd1);
    end
    check("t3_d_gap", 32'(d_a), 32'h0);
    idle_a = 1'b1;
    step();
    check("t3_idle_in_gap", 32'(idle_cnt_a), 32'd2);
    check("t3_ready_back",  32'(in_ready_a), 32'd1);
    step();
    check("t3_idle_cnt3", 32'(idle_cnt_a), 32'd3);
    check("t3_dec_final", 32'(dec_cnt_a),  32'd1);
    in_valid_a = 1'b0;
    idle_a = 1'b0;

    // test 4: reset during the second DRIVE cycle of code 01
    do_reset();
    send_a(1'b0, 2'b01);
    check("t4_d_drive1", 32'(d_a), 32'h2);
    step();
    check("t4_d_drive2", 32'(d_a), 32'h2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t4_d",       32'(d_a),        32'h0);
    check("t4_busy",    32'(busy_a),     32'd0);
    check("t4_ready",   32'(in_ready_a), 32'd1);
    check("t4_dec_cnt", 32'(dec_cnt_a),  32'd0);

    // test 5: 2-bit idle counter saturates at 3
    do_reset();
    in_valid_b = 1'b1;
    idle_b = 1'b1;
    for (int j = 0; j < 5; j++) begin
      step();
      check("t5_idle_cnt", 32'(idle_cnt_b), 32'((j < 3) ? (j + 1) : 3));
      check("t5_d",        32'(d_b),        32'h0);
    end
    in_valid_b = 1'b0;

    // test 6: HOLD_CYC=1, GAP_CYC=0, codes 11 then 00 at earliest edges
    do_reset();
    in_valid_c = 1'b1;
    idle_c = 1'b0;
    {y1_c, y0_c} = 2'b11;
    step();
    check("t6_d_first",  32'(d_c),        32'h8);
    check("t6_ready_lo", 32'(in_ready_c), 32'd0);
    {y1_c, y0_c} = 2'b00;
    step();
    check("t6_d_between", 32'(d_c),        32'h0);
    check("t6_ready_hi",  32'(in_ready_c), 32'd1);
    check("t6_dec_mid",   32'(dec_cnt_c),  32'd1);
    step();
    check("t6_d_second", 32'(d_c),       32'h1);
    check("t6_dec_cnt",  32'(dec_cnt_c), 32'd2);
    in_valid_c = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
